// File: rtl/bcd_conv_seq.sv
// ============================================================================
// Module   : bcd_conv_seq
// Purpose  : Sequential binary-to-BCD converter (double-dabble, 1 bit/clock).
//            Define BCD_SEG_EN to add a registered 7-segment output (seg_out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg_out
`endif
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(BIN_W + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_load   = 2'd1;
  localparam logic [1:0] c_st_shift  = 2'd2;
  localparam logic [1:0] c_st_finish = 2'd3;

  logic [1:0]          r_state;
  logic [BIN_W-1:0]    r_bin;
  logic [c_bcd_w-1:0]  r_scratch;
  logic [c_bcd_w-1:0]  w_adj;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_done;
  logic [c_bcd_w-1:0]  r_bcd;

  // Add-3 correction on every digit in parallel; digits never carry into each other
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_bin     <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state <= c_st_load;
          end
        end
        c_st_load: begin
          r_bin     <= bin_in;
          r_scratch <= '0;
          r_count   <= c_cnt_load;
          r_state   <= c_st_shift;
        end
        c_st_shift: begin
          r_scratch <= {w_adj[c_bcd_w-2:0], r_bin[BIN_W-1]};
          r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
          r_count   <= r_count - c_cnt_one;
          if (r_count == c_cnt_one) begin
            r_state <= c_st_finish;
          end
        end
        c_st_finish: begin
          r_bcd   <= r_scratch;
          r_done  <= 1'b1;
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign busy    = (r_state == c_st_load) || (r_state == c_st_shift);
  assign done    = r_done;
  assign bcd_out = r_bcd;

`ifdef BCD_SEG_EN
  logic [DIGITS-1:0]   w_show;
  logic                w_nz;
  logic [7*DIGITS-1:0] w_seg;
  logic [7*DIGITS-1:0] r_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // A digit is lit once any digit at or above it is non-zero; units always lit
  always_comb begin
    w_show = '0;
    w_nz   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_nz      = w_nz | (|r_scratch[4*i +: 4]);
      w_show[i] = w_nz | (i == 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    assign w_seg[7*g +: 7] = w_show[g] ? seg7(r_scratch[4*g +: 4]) : 7'b1111111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= '1;
    end else if (r_state == c_st_finish) begin
      r_seg <= w_seg;
    end
  end

  assign seg_out = r_seg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_seq.sv
// Testbench for bcd_conv_seq: vector table, random values against a
// decimal-arithmetic model, and hand-written handshake/reset sequences.
`default_nettype none

module tb_bcd_conv_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic                clk    = 1'b0;
  logic                rst_n  = 1'b1;
  logic                start  = 1'b0;
  logic [BIN_W-1:0]    bin_in = '0;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
`ifdef BCD_SEG_EN
  logic [7*DIGITS-1:0] seg_out;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bcd_conv_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
`ifdef BCD_SEG_EN
    ,
    .seg_out (seg_out)
`endif
  );

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal digits from plain division
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_glyph(input int unsigned d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [34:0] ref_seg(input int unsigned v);
    logic [34:0] r;
    int unsigned x;
    int nd;
    nd = 1;
    x = v;
    while (x >= 10) begin
      x = x / 10;
      nd++;
    end
    x = v;
    r = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i < nd) r[7*i +: 7] = ref_glyph(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge with the DUT idle; checks latency, value, hold and pulse width
  task automatic convert(input logic [15:0] val, input logic [19:0] exp, input string name);
    logic [19:0] prev;
    int lat;
    bit hold_ok;
    bit seen;
    prev    = bcd_out;
    bin_in  = val;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk({name, " busy"}, busy, 1);
    lat     = 0;
    hold_ok = 1'b1;
    seen    = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      tick();
      if (n == 1) bin_in = 16'($urandom);
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end else if (bcd_out !== prev) begin
        hold_ok = 1'b0;
      end
    end
    chk({name, " latency"}, lat, 18);
    chk({name, " value"}, bcd_out, exp);
    chk({name, " hold"}, hold_ok, 1);
    chk({name, " idle busy"}, busy, 0);
`ifdef BCD_SEG_EN
    chk({name, " seg"}, seg_out, ref_seg(int'(val)));
`endif
    tick();
    chk({name, " done width"}, done, 0);
    chk({name, " value held"}, bcd_out, exp);
  endtask

  initial begin : main
    logic [15:0] vals[3];
    logic [19:0] exps[3];
    int unsigned dcyc[3];
    int unsigned v;
    int ndone;
    bit seen;
    bit idle_ok;
    logic [19:0] first_val;

    vecs[0] = '{16'd198,   20'h00198};
    vecs[1] = '{16'd132,   20'h00132};
    vecs[2] = '{16'd0,     20'h00000};
    vecs[3] = '{16'd65535, 20'h65535};
    vecs[4] = '{16'd1656,  20'h01656};
    vecs[5] = '{16'd8000,  20'h08000};
    vecs[6] = '{16'd6400,  20'h06400};
    vecs[7] = '{16'd9,     20'h00009};
    vecs[8] = '{16'd10,    20'h00010};

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bcd", bcd_out, 0);
`ifdef BCD_SEG_EN
    chk("reset seg", seg_out, {35{1'b1}});
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    idle_ok = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 20'h0) idle_ok = 1'b0;
    end
    chk("idle quiet", idle_ok, 1);

    for (int i = 0; i < 9; i++) begin
      convert(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 25; i++) begin
      v = $urandom_range(0, 65535);
      convert(16'(v), ref_bcd(v), $sformatf("rand%0d", i));
    end

    // Back-to-back with start held high
    vals = '{16'd1656, 16'd8000, 16'd6400};
    exps = '{20'h01656, 20'h08000, 20'h06400};
    bin_in = vals[0];
    start  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      seen = 1'b0;
      for (int n = 0; n < 45 && !seen; n++) begin
        tick();
        if (done) seen = 1'b1;
      end
      chk($sformatf("b2b%0d seen", j), seen, 1);
      dcyc[j] = cyc;
      chk($sformatf("b2b%0d value", j), bcd_out, exps[j]);
      if (j < 2) bin_in = vals[j+1];
      else       start  = 1'b0;
    end
    chk("b2b spacing1", dcyc[1] - dcyc[0], 19);
    chk("b2b spacing2", dcyc[2] - dcyc[1], 19);
    repeat (3) tick();

    // Start while busy is ignored
    bin_in = 16'd1656;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    ndone  = 0;
    first_val = '0;
    for (int n = 1; n <= 45; n++) begin
      tick();
      if (n == 5) begin
        bin_in = 16'd9999;
        start  = 1'b1;
      end
      if (n == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) first_val = bcd_out;
      end
    end
    chk("ignore done count", ndone, 1);
    chk("ignore value", first_val, 20'h01656);
    chk("ignore held", bcd_out, 20'h01656);

    // Reset asserted mid-conversion, off the clock edge
    bin_in = 16'd8000;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (9) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst bcd", bcd_out, 0);
`ifdef BCD_SEG_EN
    chk("midrst seg", seg_out, {35{1'b1}});
`endif
    tick();
    tick();
    rst_n = 1'b1;
    idle_ok = 1'b1;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 20'h0) idle_ok = 1'b0;
    end
    chk("midrst no done", idle_ok, 1);
    convert(16'd132, 20'h00132, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_conv_seq.md
Name: bcd_conv_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly downstream of the sequential binary multiplier.
- Consumes the 16-bit product and produces packed BCD digits for display and readback.
- One bit is processed per clock behind a start/busy/done handshake.

Parameters:
BIN_W, 16, width of binary input (multiplier product width)
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_W - 1

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request conversion; sampled only in IDLE
bin_in  input  BIN_W  binary value to convert (multiplier product P)
busy  output  1  high while in LOAD or SHIFT
done  output  1  one-cycle pulse when bcd_out is updated
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (Reset=0), applied immediately regardless of clock:
  - state=IDLE, busy=0, done=0, bcd_out=0.
  - Internal shift register and bit counter cleared.
- FSM states: IDLE, LOAD, SHIFT, FINISH.
- IDLE:
  - busy=0.
  - If start=1 at a rising edge, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - Capture bin_in into the binary shift register.
  - Clear the BCD scratch register and set count=BIN_W.
  - busy=1. Go to SHIFT.
- SHIFT (exactly BIN_W cycles), each cycle:
  - Any scratch digit >= 5 gets +3 (all digits in parallel, 4-bit add, no carry between digits).
  - Then shift {scratch, binary} left by 1; the binary MSB enters scratch bit 0.
  - Decrement count. Go to FINISH after the cycle where count reaches 1.
- FINISH (1 cycle):
  - bcd_out <= scratch, done=1 for this single cycle, busy=0.
  - Return to IDLE.
- Latency:
  - start sampled at edge k.
  - bcd_out valid and done=1 after edge k+BIN_W+2, i.e. 18 cycles for BIN_W=16.
- Throughput: a new start is accepted in IDLE one cycle after done.
- Handshake and hold rules:
  - start while busy=1 or during FINISH is ignored; it is not queued.
  - bin_in is don't-care except at the LOAD edge; later changes do not affect the result.
  - bcd_out holds the last completed result until the next FINISH. Outside FINISH, bcd_out is never a partial value.
  - start held high continuously restarts a conversion at every IDLE, so conversions run back-to-back.
- Boundary values:
  - bin_in=0 gives all-zero digits.
  - bin_in=2^BIN_W-1 gives the full value with no overflow; guaranteed by the parameter constraint.
  - Every output digit is always in the range 0..9.
- Reset mid-operation: the conversion is abandoned and all outputs return to reset values. No done pulse is produced.

Optional Feature:
- Macro: BCD_SEG_EN
- Defined:
  - Adds output port seg_out, 7*DIGITS bits, active-low segments in order {g,f,e,d,c,b,a} per digit.
  - Digit 0 occupies bits [6:0].
  - Registered and updated in the same cycle as bcd_out. Reset value is all ones (blank).
  - Leading zeros are blanked (all ones). Digit 0 is always displayed.
- Not defined: no seg_out port and no segment logic; all other behaviour is identical.

Test Plan:
- Reset=0 then release, start=0 -> busy=0, done=0, bcd_out=0x00000 indefinitely.
- bin_in=198 (99*2), start pulse -> done exactly 18 cycles after start edge, bcd_out=0x00198. Repeat with 132 -> 0x00132.
- Back-to-back with start held high:
  - 1656 (69*24) -> 0x01656; 8000 (80*100) -> 0x08000; 6400 (32*200) -> 0x06400.
  - Done pulses are 19 cycles apart.
- Boundaries: bin_in=0 -> 0x00000; bin_in=65535 -> 0x65535. With BCD_SEG_EN, 0 shows only digit 0 = "0" (7'b1000000) and the upper digits are blank.
- Start 1656, change bin_in to 9999 and pulse start again at cycle 5 -> the second start is ignored, result is 0x01656, and only one done pulse occurs.
- Start 8000, assert Reset=0 at cycle 10 asynchronously (off clock edge) -> outputs clear immediately and no done pulse follows. After release, converting 132 -> 0x00132.
